// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter: double-dabble, one input bit per clock.
// Optional leading-zero blank mask enabled by defining SEQ_BIN2BCD_BLANK_EN.
module seq_bin2bcd #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf,
  output logic [D-1:0]   blank
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [4*D-1:0]   dig_q, dig_d;
  logic             ovs_q, ovs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [4*D-1:0]   bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [4*D-1:0]   adj;
  logic [4*D-1:0]   dig_shift;
  logic             ovf_shift;
  logic             last;

  // One double-dabble step: add-3 correction per digit, then shift in the binary MSB.
  always_comb begin
    adj = dig_q;
    for (int i = 0; i < int'(D); i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
    dig_shift = {adj[4*D-2:0], sh_q[W-1]};
    ovf_shift = ovs_q | adj[4*D-1];
  end

  assign last = (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    ovs_d   = ovs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_d    = bin;
          dig_d   = '0;
          ovs_d   = 1'b0;
          cnt_d   = CW'(W);
          state_d = StConv;
        end
      end
      StConv: begin
        sh_d  = sh_q << 1;
        dig_d = dig_shift;
        ovs_d = ovf_shift;
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          bcd_d   = dig_shift;
          ovf_d   = ovf_shift;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      dig_q   <= '0;
      ovs_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      ovs_q   <= ovs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StConv);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

`ifdef SEQ_BIN2BCD_BLANK_EN
  logic [D-1:0] blank_calc;
  logic [D-1:0] blank_q;
  logic         zero_run;

  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int i = int'(D) - 1; i >= 1; i--) begin
      zero_run      = zero_run & (dig_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (state_q == StConv && last) begin
      blank_q <= blank_calc;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd: three parameterisations, directed plan
// steps followed by random conversions checked against an arithmetic model.
module tb_seq_bin2bcd;

`ifdef SEQ_BIN2BCD_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic [15:0] binv [3];
  logic [2:0]  busy, done, ovf;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [19:0] bcd2;
  logic [2:0]  blank0;
  logic [1:0]  blank1;
  logic [4:0]  blank2;

  int unsigned wv [3] = '{8, 8, 16};
  int unsigned dv [3] = '{3, 2, 5};
  int          sel;
  int          ncmp;
  int          nfail;
  logic [19:0] prev_bcd [3];
  logic        prev_ovf [3];
  logic [4:0]  prev_blank [3];

  logic [19:0] o_bcd;
  logic [4:0]  o_blank;
  logic        o_busy, o_done, o_ovf;

  seq_bin2bcd #(.W(8), .D(3)) u_w8d3 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .bin(binv[0][7:0]),
    .busy(busy[0]), .done(done[0]), .bcd(bcd0), .ovf(ovf[0]), .blank(blank0)
  );
  seq_bin2bcd #(.W(8), .D(2)) u_w8d2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .bin(binv[1][7:0]),
    .busy(busy[1]), .done(done[1]), .bcd(bcd1), .ovf(ovf[1]), .blank(blank1)
  );
  seq_bin2bcd #(.W(16), .D(5)) u_w16d5 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .bin(binv[2]),
    .busy(busy[2]), .done(done[2]), .bcd(bcd2), .ovf(ovf[2]), .blank(blank2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_busy = busy[0]; o_done = done[0]; o_ovf = ovf[0];
    o_bcd = {8'd0, bcd0}; o_blank = {2'd0, blank0};
    if (sel == 1) begin
      o_busy = busy[1]; o_done = done[1]; o_ovf = ovf[1];
      o_bcd = {12'd0, bcd1}; o_blank = {3'd0, blank1};
    end else if (sel == 2) begin
      o_busy = busy[2]; o_done = done[2]; o_ovf = ovf[2];
      o_bcd = bcd2; o_blank = blank2;
    end
  end

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p = 1;
    for (int i = 0; i < int'(n); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned d);
    logic [19:0] r = '0;
    int unsigned m = v % pow10(d);
    for (int i = 0; i < int'(d); i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int unsigned v, input int unsigned d);
    logic [4:0] r = '0;
    int unsigned m = v % pow10(d);
    if (BlankEn) begin
      for (int i = 1; i < int'(d); i++) r[i] = (m < pow10(i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge of the done cycle.
  task automatic run(input int s, input int unsigned v, input int inj);
    int unsigned w = wv[s];
    int unsigned d = dv[s];
    sel = s;
    start[s] = 1'b1;
    binv[s] = 16'(v);
    @(posedge clk); @(negedge clk);
    start[s] = 1'b0;
    binv[s] = 16'($urandom);
    chk("busy_accept", 32'(o_busy), 32'd1);
    chk("done_accept", 32'(o_done), 32'd0);
    for (int n = 1; n <= int'(w); n++) begin
      @(posedge clk); @(negedge clk);
      start[s] = (n == inj);
      if (n == inj) binv[s] = 16'd200;
      chk("done_timing", 32'(o_done), 32'(n == int'(w)));
      chk("busy_timing", 32'(o_busy), 32'(n < int'(w)));
      if (n < int'(w)) chk("bcd_hold", 32'(o_bcd), 32'(prev_bcd[s]));
    end
    chk("bcd", 32'(o_bcd), 32'(ref_bcd(v, d)));
    chk("ovf", 32'(o_ovf), 32'(v >= pow10(d)));
    chk("blank", 32'(o_blank), 32'(ref_blank(v, d)));
    prev_bcd[s] = ref_bcd(v, d);
    prev_ovf[s] = (v >= pow10(d));
    prev_blank[s] = ref_blank(v, d);
  endtask

  task automatic idle(input int s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_done", 32'(o_done), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_bcd", 32'(o_bcd), 32'(prev_bcd[s]));
      chk("idle_ovf", 32'(o_ovf), 32'(prev_ovf[s]));
    end
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    sel = 0;
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      binv[i] = '0;
      prev_bcd[i] = '0;
      prev_ovf[i] = 1'b0;
      prev_blank[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_bcd", 32'(o_bcd), 32'd0);
      chk("rst_ovf", 32'(o_ovf), 32'd0);
      chk("rst_blank", 32'(o_blank), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 255, 0);
    run(0, 0, 0);
    run(0, 7, 0);
    idle(0, 1);
    run(0, 99, 3);
    idle(0, 2);
    run(1, 200, 0);
    run(1, 42, 0);
    idle(1, 1);
    run(2, 65535, 0);
    run(2, 1000, 0);
    idle(2, 1);
    run(0, 200, 0);

    // Abort a conversion with an asynchronous reset.
    sel = 0;
    start[0] = 1'b1;
    binv[0] = 16'd123;
    @(posedge clk); @(negedge clk);
    start[0] = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_bcd", 32'(o_bcd), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_ovf", 32'(o_ovf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      prev_bcd[i] = '0;
      prev_ovf[i] = 1'b0;
      prev_blank[i] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 10);
    run(0, 123, 0);

    for (int k = 0; k < 40; k++) begin
      int s;
      int unsigned v;
      s = int'($urandom_range(0, 2));
      v = (wv[s] == 16) ? ($urandom & 32'hffff) : ($urandom & 32'hff);
      run(s, v, (k % 5 == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 1) idle(s, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
